// File: rtl/icache_direct_if.sv
// ============================================================================
// Module      : icache_direct_if
// Description : Fetch-port and memory-port signal bundle for icache_direct.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface icache_direct_if #(
    parameter int CNT_W = 32
);
    logic             imemREN;
    logic [31:0]      imemaddr;
    logic             ihit;
    logic [31:0]      imemload;
    logic             iREN;
    logic [31:0]      iaddr;
    logic             iwait;
    logic [31:0]      iload;
    logic             inval;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    // Cache side
    modport slave (
        input  imemREN, imemaddr, iwait, iload, inval,
        output ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

    // Datapath / memory-controller side
    modport master (
        output imemREN, imemaddr, iwait, iload, inval,
        input  ihit, imemload, iREN, iaddr, hit_count, miss_count
    );
endinterface

`default_nettype wire

// File: rtl/icache_direct.sv
// ============================================================================
// Module      : icache_direct
// Description : Direct-mapped, one-word-per-block instruction cache with
//               single-word fill and saturating hit/miss statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_direct #(
    parameter int SETS  = 16,
    parameter int CNT_W = 32
) (
    input  logic            CLK,
    input  logic            RST,
    icache_direct_if.slave  bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 2;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [31:0]       r_data [SETS];
    logic [29:0]       r_miss_word;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_miss_idx;
    logic              w_hit;
    logic              w_miss;
    logic              w_fill_done;

    assign w_idx      = bus.imemaddr[IDX_W+1:2];
    assign w_tag      = bus.imemaddr[31:IDX_W+2];
    assign w_miss_idx = r_miss_word[IDX_W-1:0];

    always_comb begin
        w_next       = r_state;
        w_hit        = 1'b0;
        w_miss       = 1'b0;
        w_fill_done  = 1'b0;
        bus.iREN     = 1'b0;
        bus.iaddr    = 32'h0;
        case (r_state)
            IDLE: begin
                // inval suppresses both the hit and a new miss this cycle
                w_hit  = bus.imemREN & ~bus.inval & r_valid[w_idx]
                         & (r_tag[w_idx] == w_tag);
                w_miss = bus.imemREN & ~bus.inval & ~w_hit;
                if (w_miss) begin
                    w_next = FETCH;
                end
            end
            FETCH: begin
                bus.iREN  = 1'b1;
                bus.iaddr = {r_miss_word, 2'b00};
                if (!bus.iwait) begin
                    w_fill_done = 1'b1;
                    w_next      = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        bus.ihit     = w_hit;
        bus.imemload = w_hit ? r_data[w_idx] : 32'h0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_miss_word <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_miss) begin
                r_miss_word <= bus.imemaddr[31:2];
            end
            // An invalidate on the completing edge leaves the new frame invalid
            if (bus.inval) begin
                r_valid <= '0;
            end else if (w_fill_done) begin
                r_valid[w_miss_idx] <= 1'b1;
            end
            if (w_hit && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + c_cnt_one;
            end
            if (w_miss && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + c_cnt_one;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_fill_done) begin
            r_tag[w_miss_idx]  <= r_miss_word[29:IDX_W];
            r_data[w_miss_idx] <= bus.iload;
        end
    end

    assign bus.hit_count  = r_hit_cnt;
    assign bus.miss_count = r_miss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_icache_direct.sv
// ============================================================================
// Module      : tb_icache_direct
// Description : Scoreboard bench for icache_direct (SETS=16, CNT_W=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_direct;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_hit_q  [$];
    logic [31:0] exp_fill_q [$];

    icache_direct_if #(.CNT_W(32)) bus ();

    icache_direct #(.SETS(16), .CNT_W(32)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input logic [31:0] h, input logic [31:0] m);
        chk("hit_count", bus.hit_count, h);
        chk("miss_count", bus.miss_count, m);
    endtask

    // Monitor: every hit must match the next expected word, every fill
    // completion must target the next expected address.
    always @(negedge clk) begin
        logic [31:0] e;
        if (bus.ihit || exp_hit_q.size() > 0) begin
            if (exp_hit_q.size() == 0) begin
                chk("unexpected_hit", {31'h0, bus.ihit}, 32'h0);
            end else begin
                e = exp_hit_q.pop_front();
                chk("ihit", {31'h0, bus.ihit}, 32'h1);
                chk("imemload", bus.imemload, e);
            end
        end
        if (bus.iREN && !bus.iwait) begin
            if (exp_fill_q.size() == 0) begin
                chk("unexpected_fill", bus.iaddr, 32'hFFFF_FFFF);
            end else begin
                e = exp_fill_q.pop_front();
                chk("fill_iaddr", bus.iaddr, e);
            end
        end
    end

    // Present hit accesses; entered and left just after a rising edge.
    task automatic hit(input logic [31:0] addr, input logic [31:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            bus.imemREN  = 1'b1;
            bus.imemaddr = addr;
            exp_hit_q.push_back(data);
            @(negedge clk);
            chk("hit_iREN", {31'h0, bus.iREN}, 32'h0);
            @(posedge clk); #1;
        end
    endtask

    // Miss on addr, hold iwait for 'waits' cycles, then complete with data.
    task automatic fill(input logic [31:0] addr, input int waits, input logic [31:0] data,
                        input logic inv_wait, input logic inv_done, input logic [31:0] redirect);
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        bus.iwait    = 1'b1;
        bus.iload    = 32'h0;
        @(negedge clk);
        chk("idle_iREN", {31'h0, bus.iREN}, 32'h0);
        @(posedge clk); #1;
        for (int i = 0; i < waits; i++) begin
            if (inv_wait && i == 0) bus.inval = 1'b1;
            @(negedge clk);
            chk("wait_iREN", {31'h0, bus.iREN}, 32'h1);
            chk("wait_iaddr", bus.iaddr, {addr[31:2], 2'b00});
            chk("wait_ihit", {31'h0, bus.ihit}, 32'h0);
            @(posedge clk); #1;
            bus.inval = 1'b0;
            if (redirect != 32'h0) bus.imemaddr = redirect;
        end
        bus.iwait = 1'b0;
        bus.iload = data;
        bus.inval = inv_done;
        exp_fill_q.push_back({addr[31:2], 2'b00});
        @(negedge clk);
        chk("done_iREN", {31'h0, bus.iREN}, 32'h1);
        @(posedge clk); #1;
        bus.iwait = 1'b1;
        bus.iload = 32'h0;
        bus.inval = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h0;
        bus.iwait    = 1'b1;
        bus.iload    = 32'h0;
        bus.inval    = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ihit", {31'h0, bus.ihit}, 32'h0);
        chk("rst_imemload", bus.imemload, 32'h0);
        chk("rst_iREN", {31'h0, bus.iREN}, 32'h0);
        chk("rst_iaddr", bus.iaddr, 32'h0);
        chk_cnt(0, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // First miss with two wait cycles, then five hits
        fill(32'h40, 2, 32'h2001_0005, 1'b0, 1'b0, 32'h0);
        hit(32'h40, 32'h2001_0005, 1);
        chk_cnt(1, 1);
        hit(32'h40, 32'h2001_0005, 4);
        chk_cnt(5, 1);

        // Conflict on index 0
        fill(32'h80, 0, 32'hAAAA_0080, 1'b0, 1'b0, 32'h0);
        hit(32'h80, 32'hAAAA_0080, 1);
        fill(32'h40, 1, 32'h2001_0005, 1'b0, 1'b0, 32'h0);
        hit(32'h40, 32'h2001_0005, 1);
        chk_cnt(7, 3);

        // Redirect during fill: latched address is kept
        fill(32'h104, 2, 32'h1111_0104, 1'b0, 1'b0, 32'h200);
        fill(32'h200, 0, 32'h2222_0200, 1'b0, 1'b0, 32'h0);
        hit(32'h200, 32'h2222_0200, 1);
        hit(32'h104, 32'h1111_0104, 1);
        chk_cnt(9, 5);

        // Invalidate in IDLE masks the hit and delays the miss
        fill(32'h44, 0, 32'h3333_0044, 1'b0, 1'b0, 32'h0);
        hit(32'h44, 32'h3333_0044, 1);
        bus.inval = 1'b1;
        @(negedge clk);
        chk_cnt(10, 6);
        @(posedge clk); #1;
        bus.inval = 1'b0;
        fill(32'h44, 0, 32'h3333_0044, 1'b0, 1'b0, 32'h0);
        chk_cnt(10, 7);
        hit(32'h44, 32'h3333_0044, 1);

        // Invalidate on the completing edge: frame left invalid
        fill(32'h48, 0, 32'h4444_0048, 1'b0, 1'b1, 32'h0);
        fill(32'h48, 0, 32'h4444_0048, 1'b0, 1'b0, 32'h0);
        hit(32'h48, 32'h4444_0048, 1);
        chk_cnt(12, 9);

        // Invalidate while waiting: old frames cleared, new fill installs
        fill(32'h4C, 1, 32'h5555_004C, 1'b1, 1'b0, 32'h0);
        hit(32'h4C, 32'h5555_004C, 1);
        fill(32'h48, 0, 32'h4444_0048, 1'b0, 1'b0, 32'h0);
        hit(32'h48, 32'h4444_0048, 1);
        chk_cnt(14, 11);

        // Reset in the middle of a fill
        hit(32'h4C, 32'h5555_004C, 1);
        bus.imemaddr = 32'h80;
        bus.iwait    = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_iREN", {31'h0, bus.iREN}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_iREN", {31'h0, bus.iREN}, 32'h0);
        chk("mid_rst_iaddr", bus.iaddr, 32'h0);
        chk("mid_rst_ihit", {31'h0, bus.ihit}, 32'h0);
        chk_cnt(0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        fill(32'h4C, 0, 32'h6666_004C, 1'b0, 1'b0, 32'h0);
        hit(32'h4C, 32'h6666_004C, 1);
        chk_cnt(1, 1);

        bus.imemREN = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        chk("hit_q_drained", exp_hit_q.size(), 32'h0);
        chk("fill_q_drained", exp_fill_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
